// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer and the arm controller.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    HUNT,
    GET_OP,
    GET_ARG,
    GET_CHK
  } frame_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_MOVE = 8'h01;
  localparam logic [7:0] OP_HOME = 8'h02;
  localparam logic [7:0] OP_STOP = 8'h03;
  localparam logic [7:0] OP_GRIP = 8'h04;

  function automatic logic [7:0] frame_chk(input logic [7:0] op, input logic [7:0] arg);
    return op ^ arg;
  endfunction

endpackage

// File: rtl/rx_strobe_qualifier.sv
// Turns a receiver strobe that may stay high or chatter into one accept pulse per byte.
module rx_strobe_qualifier #(
  parameter int unsigned QUIET_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_ack,
  output logic accept
);

  localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);

  logic [QW-1:0] quiet_cnt;
  logic          armed;

  assign accept = rx_ack && armed;

  // Any high cycle restarts the quiet window, so chatter never re-arms early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b1;
      quiet_cnt <= '0;
    end else if (rx_ack) begin
      armed     <= 1'b0;
      quiet_cnt <= '0;
    end else if (!armed) begin
      if (quiet_cnt == QW'(QUIET_CYCLES - 1)) begin
        armed     <= 1'b1;
        quiet_cnt <= '0;
      end else begin
        quiet_cnt <= quiet_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames qualified UART bytes into sync/op/arg/checksum commands with a one-entry output register.
// Optional statistics counters are built when UART_CMD_PARSER_STATS_EN is defined.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned QUIET_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_ack,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_arg,
  output logic        err_chk,
  output logic        err_timeout,
  output logic        err_overflow,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  frame_state_t  state;
  logic [7:0]    op_q;
  logic [7:0]    arg_q;
  logic [TW-1:0] idle_cnt;
  logic          accept;
  logic          frame_done;
  logic          frame_good;
  logic          frame_bad;
  logic          timeout_hit;
  logic          out_free;

  rx_strobe_qualifier #(
    .QUIET_CYCLES(QUIET_CYCLES)
  ) u_qual (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_ack(rx_ack),
    .accept(accept)
  );

  assign frame_done  = accept && (state == GET_CHK);
  assign frame_good  = frame_done && (rx_data == frame_chk(op_q, arg_q));
  assign frame_bad   = frame_done && !frame_good;
  assign timeout_hit = (state != HUNT) && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES));
  assign out_free    = !cmd_valid || cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      op_q         <= '0;
      arg_q        <= '0;
      idle_cnt     <= '0;
      cmd_valid    <= 1'b0;
      cmd_op       <= '0;
      cmd_arg      <= '0;
      err_chk      <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_chk      <= frame_bad;
      err_timeout  <= timeout_hit;
      err_overflow <= frame_good && !out_free;

      // A load in the same cycle as a handshake overrides the drop of cmd_valid.
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;
      if (frame_good && out_free) begin
        cmd_valid <= 1'b1;
        cmd_op    <= op_q;
        cmd_arg   <= arg_q;
      end

      if (state == HUNT || accept || timeout_hit) idle_cnt <= '0;
      else if (idle_cnt != '1)                    idle_cnt <= idle_cnt + 1'b1;

      if (timeout_hit) begin
        state <= HUNT;
      end else if (accept) begin
        case (state)
          HUNT:    if (rx_data == SYNC_BYTE) state <= GET_OP;
          GET_OP:  begin op_q  <= rx_data; state <= GET_ARG; end
          GET_ARG: begin arg_q <= rx_data; state <= GET_CHK; end
          GET_CHK: state <= HUNT;
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef UART_CMD_PARSER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good <= '0;
      stat_bad  <= '0;
    end else begin
      if (frame_good && stat_good != '1) stat_good <= stat_good + 1'b1;
      if ((frame_bad || timeout_hit) && stat_bad != '1) stat_bad <= stat_bad + 1'b1;
    end
  end
`else
  assign stat_good = '0;
  assign stat_bad  = '0;
`endif

endmodule
